// File: rtl/wb_sram_responder.sv
// wb_sram_responder: Wishbone slave RAM with classic and CTI/BTE burst support,
// programmable wait states per beat, and ERR for addresses outside the RAM window.
module wb_sram_responder #(
    parameter int                       WB_ADDR_WIDTH  = 32,
    parameter int                       WB_DATA_WIDTH  = 32,
    parameter int                       MEM_ADDR_WIDTH = 10,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                       WAIT_STATES    = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WB_ADDR_WIDTH-1:0]     ADR,
    input  logic [2:0]                   CTI,
    input  logic [1:0]                   BTE,
    input  logic [WB_DATA_WIDTH-1:0]     DAT_W,
    input  logic [WB_DATA_WIDTH/8-1:0]   SEL,
    input  logic                         WE,
    input  logic                         CYC,
    input  logic                         STB,
    output logic [WB_DATA_WIDTH-1:0]     DAT_R,
    output logic                         ACK,
    output logic                         ERR,
    output logic [1:0]                   fsm_state
);

    localparam int SEL_W     = WB_DATA_WIDTH / 8;
    localparam int MEM_WORDS = 1 << MEM_ADDR_WIDTH;
    localparam logic [WB_ADDR_WIDTH:0] WIN_BYTES =
        {{WB_ADDR_WIDTH{1'b0}}, 1'b1} << (MEM_ADDR_WIDTH + 2);
    localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    // Handshake: a beat completes on the rising edge where CYC, STB and ACK (or ERR)
    // are all high; ACK/ERR are only ever driven while the master holds CYC and STB.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WB_DATA_WIDTH-1:0]  mem [0:MEM_WORDS-1];
    logic [WB_DATA_WIDTH-1:0]  dat_q;
    logic [MEM_ADDR_WIDTH-1:0] beat_idx, next_idx, adr_idx, wrap_mask;
    logic [WB_ADDR_WIDTH-1:0]  adr_off;
    logic [3:0]                wait_cnt;
    logic                      err_q, burst_q;
    logic                      cyc_stb, adr_in_win, resp_live, err_hit;
    logic                      load_beat, burst_go, mem_we;

    assign cyc_stb    = CYC & STB;
    assign adr_off    = ADR - BASE_ADDR;
    assign adr_in_win = (ADR >= BASE_ADDR) && ({1'b0, adr_off} < WIN_BYTES);
    assign adr_idx    = adr_off[MEM_ADDR_WIDTH+1:2];

    // First beat uses the registered window check; continuation beats of a burst
    // are checked against the address the master is presenting right now.
    assign resp_live = (state == S_RESP) && cyc_stb;
    assign err_hit   = err_q | (burst_q & ~adr_in_win);
    assign ACK       = resp_live & ~err_hit;
    assign ERR       = resp_live & err_hit;
    assign DAT_R     = ACK ? dat_q : '0;
    assign fsm_state = state;

    assign mem_we    = ACK & WE & ~reset;
    assign load_beat = cyc_stb &&
                       (((state == S_IDLE) && (WAIT_STATES == 0)) ||
                        ((state == S_WAIT) && (wait_cnt == WAIT_LAST)));
    assign burst_go  = ACK && (CTI == 3'b010) && (WAIT_STATES == 0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (cyc_stb) state_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            S_WAIT: if (cyc_stb && (wait_cnt == WAIT_LAST)) state_next = S_RESP;
            S_RESP: if (cyc_stb && !burst_go) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (!CYC) begin
            state_next = S_IDLE;
        end
    end

    // Wrap-N bursts only advance the low log2(N) index bits; linear wraps the whole RAM.
    always_comb begin
        wrap_mask = '1;
        case (BTE)
            2'b01:   wrap_mask = MEM_ADDR_WIDTH'(3);
            2'b10:   wrap_mask = MEM_ADDR_WIDTH'(7);
            2'b11:   wrap_mask = MEM_ADDR_WIDTH'(15);
            default: wrap_mask = '1;
        endcase
        next_idx = (beat_idx & ~wrap_mask) | ((beat_idx + 1'b1) & wrap_mask);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
            dat_q    <= '0;
            err_q    <= 1'b0;
            burst_q  <= 1'b0;
            beat_idx <= '0;
        end else begin
            if (state == S_IDLE) begin
                wait_cnt <= '0;
            end else if ((state == S_WAIT) && cyc_stb) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (load_beat) begin
                beat_idx <= adr_idx;
                dat_q    <= mem[adr_idx];
                err_q    <= ~adr_in_win;
                burst_q  <= 1'b0;
            end else if (burst_go) begin
                beat_idx <= next_idx;
                dat_q    <= mem[next_idx];
                err_q    <= 1'b0;
                burst_q  <= 1'b1;
            end
        end
    end

    // RAM is deliberately not reset; writes land on the address presented with the beat.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < SEL_W; i++) begin
                if (SEL[i]) begin
                    mem[adr_idx][8*i +: 8] <= DAT_W[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_sram_responder.sv
// Bench for wb_sram_responder: one instance with no wait states, one with two,
// driven by Wishbone tasks and checked against a word-array model of the RAM.
module tb_wb_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic [31:0] adr   [2];
  logic [2:0]  cti   [2];
  logic [1:0]  bte   [2];
  logic [31:0] dat_w [2];
  logic [3:0]  sel   [2];
  logic        we    [2];
  logic        cyc   [2];
  logic        stb   [2];
  logic [31:0] dat_r [2];
  logic        ack   [2];
  logic        err   [2];
  logic [1:0]  fsm   [2];

  wb_sram_responder #(.WAIT_STATES(0)) dut0 (
    .clock(clk), .reset(rst[0]), .ADR(adr[0]), .CTI(cti[0]), .BTE(bte[0]),
    .DAT_W(dat_w[0]), .SEL(sel[0]), .WE(we[0]), .CYC(cyc[0]), .STB(stb[0]),
    .DAT_R(dat_r[0]), .ACK(ack[0]), .ERR(err[0]), .fsm_state(fsm[0])
  );

  wb_sram_responder #(.WAIT_STATES(2)) dut2 (
    .clock(clk), .reset(rst[1]), .ADR(adr[1]), .CTI(cti[1]), .BTE(bte[1]),
    .DAT_W(dat_w[1]), .SEL(sel[1]), .WE(we[1]), .CYC(cyc[1]), .STB(stb[1]),
    .DAT_R(dat_r[1]), .ACK(ack[1]), .ERR(err[1]), .fsm_state(fsm[1])
  );

  logic [31:0] model [2][1024];
  logic [31:0] exp_q [$];
  logic [31:0] rd_v;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input int w);
    return (w == 0) ? 0 : 2;
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    return a < 32'h0000_1000;
  endfunction

  task automatic model_write(input int w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
    for (int i = 0; i < 4; i++) begin
      if (s[i]) model[w][a[11:2]][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic classic(input int w, input logic [31:0] a, input logic wr,
                         input logic [31:0] d, input logic [3:0] s, input string tag,
                         output logic [31:0] rd);
    int   lat;
    logic seen_ack, seen_err;
    logic exp_err;
    exp_err = !in_win(a);
    @(negedge clk);
    adr[w] = a; we[w] = wr; dat_w[w] = d; sel[w] = s; cti[w] = 3'b000; bte[w] = 2'b00;
    cyc[w] = 1'b1; stb[w] = 1'b1;
    lat = 0; seen_ack = 1'b0; seen_err = 1'b0; rd = '0;
    while (!seen_ack && !seen_err && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen_ack = ack[w]; seen_err = err[w]; rd = dat_r[w];
    end
    check_val($sformatf("%s_lat", tag), 32'(lat), 32'(1 + ws_of(w)));
    check_val($sformatf("%s_err", tag), 32'(seen_err), 32'(exp_err));
    check_val($sformatf("%s_ack", tag), 32'(seen_ack), 32'(!exp_err));
    if (exp_err) check_val($sformatf("%s_errdat", tag), rd, 32'h0);
    else if (!wr) check_val($sformatf("%s_rdat", tag), rd, model[w][a[11:2]]);
    if (wr && !exp_err) model_write(w, a, d, s);
    @(posedge clk);
    @(negedge clk);
    // Strobe still high here: the beat must not be acknowledged twice.
    check_val($sformatf("%s_done", tag), 32'({ack[w], err[w], fsm[w]}), 32'h0);
    cyc[w] = 1'b0; stb[w] = 1'b0; we[w] = 1'b0;
  endtask

  task automatic burst(input logic [31:0] a0, input logic [1:0] b, input int n,
                       input logic wr, input string tag);
    logic [31:0] a [16];
    logic [31:0] d [16];
    logic [3:0]  s [16];
    int nw, lat, idx0, idx_k;
    nw   = (b == 2'd1) ? 4 : (b == 2'd2) ? 8 : (b == 2'd3) ? 16 : 0;
    idx0 = int'(a0[11:2]);
    for (int k = 0; k < n; k++) begin
      if (nw == 0) idx_k = (idx0 + k) % 1024;
      else         idx_k = (idx0 / nw) * nw + ((idx0 % nw) + k) % nw;
      a[k] = 32'(idx_k * 4);
      d[k] = $urandom;
      s[k] = wr ? 4'($urandom_range(1, 15)) : 4'hF;
      if (!wr) exp_q.push_back(model[0][idx_k]);
    end
    @(negedge clk);
    adr[0] = a[0]; cti[0] = (n == 1) ? 3'b111 : 3'b010; bte[0] = b; we[0] = wr;
    dat_w[0] = d[0]; sel[0] = s[0]; cyc[0] = 1'b1; stb[0] = 1'b1;
    lat = 0;
    while (!ack[0] && !err[0] && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_val($sformatf("%s_lat", tag), 32'(lat), 32'd1);
    for (int k = 0; k < n; k++) begin
      check_val($sformatf("%s_ack%0d", tag, k), 32'(ack[0]), 32'd1);
      if (!wr && exp_q.size() > 0) check_val($sformatf("%s_dat%0d", tag, k), dat_r[0], exp_q.pop_front());
      if (wr) model_write(0, a[k], d[k], s[k]);
      @(posedge clk);
      #1;
      if (k + 1 < n) begin
        adr[0] = a[k+1]; dat_w[0] = d[k+1]; sel[0] = s[k+1];
        cti[0] = (k + 1 == n - 1) ? 3'b111 : 3'b010;
      end
      @(negedge clk);
    end
    check_val($sformatf("%s_end", tag), 32'({ack[0], err[0], fsm[0]}), 32'h0);
    cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0; cti[0] = 3'b000;
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    for (int w = 0; w < 2; w++) begin
      rst[w] = 1'b1; adr[w] = '0; cti[w] = '0; bte[w] = '0; dat_w[w] = '0;
      sel[w] = '0; we[w] = 1'b0; cyc[w] = 1'b0; stb[w] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      check_val("reset_flags", 32'({ack[w], err[w], fsm[w]}), 32'h0);
      check_val("reset_dat_r", dat_r[w], 32'h0);
      adr[w] = 32'h10; cyc[w] = 1'b1; stb[w] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      check_val("reset_hold", 32'({ack[w], err[w], fsm[w]}), 32'h0);
      cyc[w] = 1'b0; stb[w] = 1'b0; rst[w] = 1'b0;
    end

    // Classic write/read and byte-lane merge.
    classic(0, 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, "t1_wr", rd_v);
    classic(0, 32'h10, 1'b0, 32'h0, 4'hF, "t1_rd", rd_v);
    check_val("t1_value", rd_v, 32'hDEAD_BEEF);
    classic(0, 32'h20, 1'b1, 32'h1122_3344, 4'hF, "t2_pre", rd_v);
    classic(0, 32'h20, 1'b1, 32'h0000_AB00, 4'b0010, "t2_wr", rd_v);
    classic(0, 32'h20, 1'b0, 32'h0, 4'hF, "t2_rd", rd_v);
    check_val("t2_value", rd_v, 32'h1122_AB44);

    // Linear burst write then read back.
    burst(32'h0, 2'b00, 4, 1'b1, "t3_wr");
    burst(32'h0, 2'b00, 4, 1'b0, "t3_rd");

    // Wrap4 read from word 2.
    classic(0, 32'h0, 1'b1, 32'hA0, 4'hF, "t4_p0", rd_v);
    classic(0, 32'h4, 1'b1, 32'hA1, 4'hF, "t4_p1", rd_v);
    classic(0, 32'h8, 1'b1, 32'hA2, 4'hF, "t4_p2", rd_v);
    classic(0, 32'hC, 1'b1, 32'hA3, 4'hF, "t4_p3", rd_v);
    burst(32'h8, 2'b01, 4, 1'b0, "t4_wrap");

    // Out-of-window write aliases word 0 and must leave it alone.
    classic(0, 32'h1000, 1'b1, 32'h1234_5678, 4'hF, "t5_err", rd_v);
    classic(0, 32'h0, 1'b0, 32'h0, 4'hF, "t5_rd", rd_v);
    check_val("t5_value", rd_v, 32'hA0);

    // Wait states and reset while waiting.
    classic(1, 32'h40, 1'b1, 32'h5A5A_5A5A, 4'hF, "t6_pre", rd_v);
    @(negedge clk);
    adr[1] = 32'h40; we[1] = 1'b1; dat_w[1] = 32'hFFFF_FFFF; sel[1] = 4'hF;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("t6_wait_noack", 32'(ack[1]), 32'd0);
    rst[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    check_val("t6_reset_idle", 32'({ack[1], err[1], fsm[1]}), 32'h0);
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    begin
      logic any_ack;
      any_ack = 1'b0;
      repeat (4) begin
        @(negedge clk);
        any_ack = any_ack | ack[1] | err[1];
      end
      check_val("t6_no_ack", 32'(any_ack), 32'd0);
    end
    classic(1, 32'h40, 1'b0, 32'h0, 4'hF, "t6_rd", rd_v);
    check_val("t6_value", rd_v, 32'h5A5A_5A5A);

    // Randomized classic traffic on both instances over words 64..79.
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 16; i++) begin
        classic(w, 32'(256 + 4 * i), 1'b1, $urandom, 4'hF, "rnd_pre", rd_v);
      end
      for (int i = 0; i < 30; i++) begin
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'(4 * $urandom_range(0, 255));
        else                           a = 32'(256 + 4 * $urandom_range(0, 15));
        classic(w, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                $sformatf("rnd_c%0d_%0d", w, i), rd_v);
      end
    end

    // Randomized bursts on the zero-wait instance.
    for (int i = 0; i < 10; i++) begin
      logic [1:0] b;
      int nw, n, st;
      b  = 2'($urandom_range(0, 3));
      nw = (b == 2'd1) ? 4 : (b == 2'd2) ? 8 : (b == 2'd3) ? 16 : 0;
      n  = (nw != 0) ? nw : $urandom_range(2, 6);
      st = (nw != 0) ? 64 + $urandom_range(0, 15) : 64 + $urandom_range(0, 16 - n);
      burst(32'(st * 4), b, n, 1'($urandom_range(0, 1)), $sformatf("rnd_b%0d", i));
    end
    for (int i = 0; i < 16; i++) begin
      classic(0, 32'(256 + 4 * i), 1'b0, 32'h0, 4'hF, "rnd_final", rd_v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
